// File: rtl/multicycle_ctrl_pkg.sv
// riscv_ctrl_pkg: shared encodings for the multicycle RV32 control unit.
// Holds the FSM state codes, opcode constants, ALU control codes, the
// operand/result/immediate select codes and the ALU decoder class type.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECR   = 4'd6,
    S_EXECI   = 4'd7,
    S_ALUWB   = 4'd8,
    S_BEQ     = 4'd9,
    S_JAL     = 4'd10,
    S_ILLEGAL = 4'd11
  } state_e;

  // Tells the ALU decoder how to interpret funct3/funct7b5 in this state.
  typedef enum logic [1:0] {
    ALU_CLASS_ADD = 2'd0,
    ALU_CLASS_SUB = 2'd1,
    ALU_CLASS_R   = 2'd2,
    ALU_CLASS_I   = 2'd3
  } alu_class_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Immediate format follows the opcode alone, independent of FSM state.
  function automatic logic [1:0] imm_format(input logic [6:0] op);
    case (op)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_JAL:    return IMM_J;
      default:   return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// alu_decoder: combinational ALU control selection.
// Ports:
//   alu_class  in  class of operation requested by the FSM state
//   funct3     in  instr[14:12]
//   funct7b5   in  instr[30]
//   aluctrl    out ALU operation code
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  alu_class_e  alu_class,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  output logic [3:0]  aluctrl
);

  always_comb begin
    aluctrl = ALU_ADD;
    case (alu_class)
      ALU_CLASS_ADD: aluctrl = ALU_ADD;
      ALU_CLASS_SUB: aluctrl = ALU_SUB;
      default: begin
        case (funct3)
          // Immediate forms have no SUBI; bit 30 is part of the immediate.
          3'b000:  aluctrl = (alu_class == ALU_CLASS_R && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  aluctrl = ALU_SLL;
          3'b010:  aluctrl = ALU_SLT;
          3'b011:  aluctrl = ALU_SLTU;
          3'b100:  aluctrl = ALU_XOR;
          3'b101:  aluctrl = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  aluctrl = ALU_OR;
          default: aluctrl = ALU_AND;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore-style control FSM for a multicycle RV32 subset
// (loads, stores, R/I ALU ops, BEQ, JAL).
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   opcode, funct3, funct7b5     fields of the latched instruction
//   zero                         ALU zero flag (gates the BEQ PC write)
//   mem_ready                    data RAM access-complete handshake
//   pc_we, ir_we, regwrite       write enables
//   memread, memwrite, mem_req   data RAM controls
//   alusrc_a, alusrc_b, aluctrl  ALU operand selects and operation
//   resultsrc, immsrc            result mux and immediate format
//   illegal                      sticky unsupported-opcode flag
//   instret                      retired instruction count
//   state                        current FSM state code
module multicycle_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 pc_we,
  output logic                 ir_we,
  output logic                 regwrite,
  output logic                 memread,
  output logic                 memwrite,
  output logic                 mem_req,
  output logic [1:0]           alusrc_a,
  output logic [1:0]           alusrc_b,
  output logic [3:0]           aluctrl,
  output logic [1:0]           resultsrc,
  output logic [1:0]           immsrc,
  output logic                 illegal,
  output logic [INSTRET_W-1:0] instret,
  output logic [3:0]           state
);

  state_e                 state_reg, state_next;
  logic [INSTRET_W-1:0]   instret_reg;
  alu_class_e             alu_class;
  logic                   retire;
  logic pc_we_st, ir_we_st, regwrite_st, memread_st, memwrite_st, mem_req_st;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_FETCH;
      instret_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (retire) instret_reg <= instret_reg + 1'b1;
    end
  end

  always_comb begin
    state_next  = state_reg;
    pc_we_st    = 1'b0;
    ir_we_st    = 1'b0;
    regwrite_st = 1'b0;
    memread_st  = 1'b0;
    memwrite_st = 1'b0;
    mem_req_st  = 1'b0;
    alusrc_a    = SRCA_PC;
    alusrc_b    = SRCB_RD2;
    resultsrc   = RES_ALUOUT;
    alu_class   = ALU_CLASS_ADD;
    illegal     = 1'b0;
    case (state_reg)
      S_FETCH: begin
        ir_we_st   = 1'b1;
        pc_we_st   = 1'b1;
        alusrc_a   = SRCA_PC;
        alusrc_b   = SRCB_FOUR;
        resultsrc  = RES_ALU;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        // Speculatively form OLDPC+IMM so BEQ/JAL find the target in ALUOUT.
        alusrc_a = SRCA_OLDPC;
        alusrc_b = SRCB_IMM;
        case (opcode)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_RTYPE:          state_next = S_EXECR;
          OP_ITYPE:          state_next = S_EXECI;
          OP_BRANCH:         state_next = S_BEQ;
          OP_JAL:            state_next = S_JAL;
          default:           state_next = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        alusrc_a   = SRCA_RD1;
        alusrc_b   = SRCB_IMM;
        state_next = (opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        memread_st = 1'b1;
        mem_req_st = 1'b1;
        if (mem_ready) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        regwrite_st = 1'b1;
        resultsrc   = RES_RDATA;
        state_next  = S_FETCH;
      end
      S_MEMWR: begin
        memwrite_st = 1'b1;
        mem_req_st  = 1'b1;
        if (mem_ready) state_next = S_FETCH;
      end
      S_EXECR: begin
        alusrc_a   = SRCA_RD1;
        alusrc_b   = SRCB_RD2;
        alu_class  = ALU_CLASS_R;
        state_next = S_ALUWB;
      end
      S_EXECI: begin
        alusrc_a   = SRCA_RD1;
        alusrc_b   = SRCB_IMM;
        alu_class  = ALU_CLASS_I;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        regwrite_st = 1'b1;
        resultsrc   = RES_ALUOUT;
        state_next  = S_FETCH;
      end
      S_BEQ: begin
        alusrc_a   = SRCA_RD1;
        alusrc_b   = SRCB_RD2;
        alu_class  = ALU_CLASS_SUB;
        resultsrc  = RES_ALUOUT;
        pc_we_st   = zero;
        state_next = S_FETCH;
      end
      S_JAL: begin
        // PC takes the target from ALUOUT while the ALU forms the link value.
        alusrc_a   = SRCA_OLDPC;
        alusrc_b   = SRCB_FOUR;
        resultsrc  = RES_ALUOUT;
        pc_we_st   = 1'b1;
        state_next = S_ALUWB;
      end
      default: begin
        illegal    = 1'b1;
        state_next = S_ILLEGAL;
      end
    endcase
  end

  always_comb begin
    retire = 1'b0;
    if (state_next == S_FETCH) begin
      case (state_reg)
        S_MEMWB, S_MEMWR, S_ALUWB, S_BEQ: retire = 1'b1;
        default:                          retire = 1'b0;
      endcase
    end
  end

  alu_decoder u_alu_decoder (
    .alu_class (alu_class),
    .funct3    (funct3),
    .funct7b5  (funct7b5),
    .aluctrl   (aluctrl)
  );

  // Enables are masked by rst_n so nothing writes while reset is held,
  // even though the state register already reads FETCH.
  assign pc_we    = pc_we_st    & rst_n;
  assign ir_we    = ir_we_st    & rst_n;
  assign regwrite = regwrite_st & rst_n;
  assign memread  = memread_st  & rst_n;
  assign memwrite = memwrite_st & rst_n;
  assign mem_req  = mem_req_st  & rst_n;

  assign immsrc  = imm_format(opcode);
  assign instret = instret_reg;
  assign state   = state_reg;

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic        zero;
  logic        mem_ready;
  logic        pc_we, ir_we, regwrite, memread, memwrite, mem_req;
  logic [1:0]  alusrc_a, alusrc_b, resultsrc, immsrc;
  logic [3:0]  aluctrl;
  logic        illegal;
  logic [31:0] instret;
  logic [3:0]  state;

  int checks = 0;
  int errors = 0;

  multicycle_ctrl #(.INSTRET_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
    .funct7b5(funct7b5), .zero(zero), .mem_ready(mem_ready),
    .pc_we(pc_we), .ir_we(ir_we), .regwrite(regwrite), .memread(memread),
    .memwrite(memwrite), .mem_req(mem_req), .alusrc_a(alusrc_a),
    .alusrc_b(alusrc_b), .aluctrl(aluctrl), .resultsrc(resultsrc),
    .immsrc(immsrc), .illegal(illegal), .instret(instret), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h t=%0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // {pc_we, ir_we, regwrite, memread, memwrite, mem_req}
  function automatic logic [31:0] en();
    return {26'd0, pc_we, ir_we, regwrite, memread, memwrite, mem_req};
  endfunction

  initial begin
    rst_n = 1'b0; opcode = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0;
    zero = 1'b0; mem_ready = 1'b1;
    step(); step();
    check("reset_state", {28'd0, state}, 32'd0);
    check("reset_enables", en(), 32'd0);
    check("reset_instret", instret, 32'd0);
    check("reset_illegal", {31'd0, illegal}, 32'd0);
    rst_n = 1'b1;
    #1;

    // add: FETCH, DECODE, EXECR, ALUWB, FETCH (mem_ready high is ignored)
    check("add_fetch_state", {28'd0, state}, 32'd0);
    check("add_fetch_en", en(), 32'b110000);
    check("add_fetch_srcs", {24'd0, alusrc_a, alusrc_b, resultsrc, 2'b00}, {24'd0, 8'b00_10_10_00});
    check("add_fetch_alu", {28'd0, aluctrl}, 32'h0);
    step();
    check("add_decode_state", {28'd0, state}, 32'd1);
    check("add_decode_srcs", {28'd0, alusrc_a, alusrc_b}, {28'd0, 4'b01_01});
    check("add_decode_en", en(), 32'd0);
    step();
    check("add_execr_state", {28'd0, state}, 32'd6);
    check("add_execr_alu", {28'd0, aluctrl}, 32'h0);
    check("add_execr_srcs", {28'd0, alusrc_a, alusrc_b}, {28'd0, 4'b10_00});
    check("add_execr_en", en(), 32'd0);
    step();
    check("add_aluwb_state", {28'd0, state}, 32'd8);
    check("add_aluwb_en", en(), 32'b001000);
    check("add_aluwb_res", {30'd0, resultsrc}, 32'd0);
    step();
    check("add_done_state", {28'd0, state}, 32'd0);
    check("add_instret", instret, 32'd1);

    // sub in EXECR
    funct7b5 = 1'b1;
    step(); step();
    check("sub_execr_alu", {28'd0, aluctrl}, 32'h1);
    step(); step();

    // lw with three wait cycles: 8 cycles total
    opcode = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0; mem_ready = 1'b0;
    #1;
    check("lw_immsrc", {30'd0, immsrc}, 32'd0);
    step();
    step();
    check("lw_memadr_state", {28'd0, state}, 32'd2);
    check("lw_memadr_srcs", {28'd0, alusrc_a, alusrc_b}, {28'd0, 4'b10_01});
    for (int i = 0; i < 4; i++) begin
      step();
      if (i == 3) mem_ready = 1'b1;
      #1;
      check($sformatf("lw_memrd_state_%0d", i), {28'd0, state}, 32'd3);
      check($sformatf("lw_memrd_en_%0d", i), en(), 32'b000101);
    end
    step();
    mem_ready = 1'b0;
    check("lw_memwb_state", {28'd0, state}, 32'd4);
    check("lw_memwb_en", en(), 32'b001000);
    check("lw_memwb_res", {30'd0, resultsrc}, 32'd1);
    step();
    check("lw_done_state", {28'd0, state}, 32'd0);
    check("lw_instret", instret, 32'd3);

    // beq taken, then not taken
    opcode = 7'b1100011; funct3 = 3'b000;
    for (int z = 1; z >= 0; z--) begin
      zero = z[0];
      #1;
      check("beq_immsrc", {30'd0, immsrc}, 32'd2);
      step(); step();
      check("beq_state", {28'd0, state}, 32'd9);
      check($sformatf("beq_pc_we_z%0d", z), {31'd0, pc_we}, {31'd0, z[0]});
      check("beq_alu", {28'd0, aluctrl}, 32'h1);
      check("beq_res", {30'd0, resultsrc}, 32'd0);
      step();
      check("beq_done_state", {28'd0, state}, 32'd0);
    end
    check("beq_instret", instret, 32'd5);
    zero = 1'b0;

    // srai then addi with bit 30 set
    opcode = 7'b0010011; funct3 = 3'b101; funct7b5 = 1'b1;
    step(); step();
    check("srai_state", {28'd0, state}, 32'd7);
    check("srai_alu", {28'd0, aluctrl}, 32'h7);
    check("srai_srcb", {30'd0, alusrc_b}, 32'd1);
    step(); step();
    funct3 = 3'b000;
    step(); step();
    check("addi_alu", {28'd0, aluctrl}, 32'h0);
    step(); step();
    check("addi_instret", instret, 32'd7);

    // jal: FETCH, DECODE, JAL, ALUWB
    opcode = 7'b1101111; funct7b5 = 1'b0;
    #1;
    check("jal_immsrc", {30'd0, immsrc}, 32'd3);
    step(); step();
    check("jal_state", {28'd0, state}, 32'd10);
    check("jal_en", en(), 32'b100000);
    check("jal_srcs", {28'd0, alusrc_a, alusrc_b}, {28'd0, 4'b01_10});
    step();
    check("jal_aluwb_state", {28'd0, state}, 32'd8);
    step();
    check("jal_instret", instret, 32'd8);

    // sw stalled, then reset mid-access
    opcode = 7'b0100011; funct3 = 3'b010; mem_ready = 1'b0;
    #1;
    check("sw_immsrc", {30'd0, immsrc}, 32'd1);
    step(); step(); step();
    check("sw_memwr_state", {28'd0, state}, 32'd5);
    check("sw_memwr_en", en(), 32'b000011);
    step();
    check("sw_memwr_held", {28'd0, state}, 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    check("sw_rst_en", en(), 32'd0);
    check("sw_rst_state", {28'd0, state}, 32'd0);
    check("sw_rst_instret", instret, 32'd0);
    step();
    rst_n = 1'b1;
    #1;
    check("sw_rel_en", en(), 32'b110000);
    step();
    check("sw_rel_decode", {28'd0, state}, 32'd1);

    // illegal opcode: sticky for 20 cycles, cleared by reset
    opcode = 7'b1111111;
    step();
    for (int i = 0; i < 20; i++) begin
      check($sformatf("ill_state_%0d", i), {28'd0, state}, 32'd11);
      check($sformatf("ill_flag_%0d", i), {31'd0, illegal}, 32'd1);
      check($sformatf("ill_en_%0d", i), en(), 32'd0);
      step();
    end
    rst_n = 1'b0;
    #2;
    check("ill_rst_flag", {31'd0, illegal}, 32'd0);
    rst_n = 1'b1;
    opcode = 7'b0110011;
    step();
    check("ill_after_state", {28'd0, state}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter INSTRET_W, default 32: width of the retired-instruction counter.
REQ-002 clk  in  1  single system clock; all state updates on its rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 opcode  in  7  instr[6:0] of the latched instruction register.
REQ-005 funct3  in  3  instr[14:12].
REQ-006 funct7b5  in  1  instr[30].
REQ-007 zero  in  1  ALU ZERO flag, same cycle.
REQ-008 mem_ready  in  1  data RAM access-complete handshake.
REQ-009 pc_we, ir_we, regwrite  out  1 each  PC, IR/OLDPC and register-file write enables.
REQ-010 memread, memwrite, mem_req  out  1 each  data RAM read enable, write enable and request.
REQ-011 alusrc_a  out  2  00 PC, 01 OLDPC, 10 RD1.
REQ-012 alusrc_b  out  2  00 RD2, 01 IMM, 10 constant 4.
REQ-013 aluctrl  out  4  ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001.
REQ-014 resultsrc  out  2  00 ALUOUT register, 01 RAM data, 10 live ALU result.
REQ-015 immsrc  out  2  00 I, 01 S, 10 B, 11 J; combinational from opcode in every state.
REQ-016 illegal  out  1  sticky unsupported-opcode flag.
REQ-017 instret  out  INSTRET_W  count of retired instructions.
REQ-018 state  out  4  current FSM state code, for debug.

Function
REQ-019 Moore FSM; every output except immsrc and aluctrl in EXECR/EXECI SHALL depend on state only; enables not listed for a state SHALL be 0.
REQ-020 FETCH: ir_we=1, pc_we=1, a=PC, b=4, ADD, resultsrc=10; next DECODE.
REQ-021 DECODE: a=OLDPC, b=IMM, ADD (branch/jump target to ALUOUT); next by opcode: 0000011/0100011 MEMADR, 0110011 EXECR, 0010011 EXECI, 1100011 BEQ, 1101111 JAL, else ILLEGAL.
REQ-022 MEMADR: a=RD1, b=IMM, ADD; next MEMRD for load, MEMWR for store.
REQ-023 MEMRD: memread=1, mem_req=1, held while mem_ready=0; on mem_ready=1 next MEMWB.
REQ-024 MEMWB: regwrite=1, resultsrc=01; next FETCH.
REQ-025 MEMWR: memwrite=1, mem_req=1, held while mem_ready=0; on mem_ready=1 next FETCH.
REQ-026 EXECR: a=RD1, b=RD2, aluctrl from funct3/funct7b5 (000 ADD/SUB, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA, 110 OR, 111 AND); next ALUWB.
REQ-027 EXECI: a=RD1, b=IMM, same mapping except funct3=000 always ADD; funct7b5 selects SRA only for funct3=101; next ALUWB.
REQ-028 ALUWB: regwrite=1, resultsrc=00; next FETCH.
REQ-029 BEQ: a=RD1, b=RD2, SUB, resultsrc=00, pc_we=zero; next FETCH.
REQ-030 JAL: a=OLDPC, b=4, ADD, resultsrc=00, pc_we=1; next ALUWB (writes OLDPC+4).
REQ-031 ILLEGAL: all enables 0, illegal=1; SHALL remain until reset.
REQ-032 instret SHALL increment by 1, wrapping modulo 2^INSTRET_W, on each transition into FETCH from MEMWB, MEMWR, ALUWB or BEQ.
REQ-033 Latency: R/I-type 4 cycles, BEQ 3, JAL 4, store 4+waits, load 5+waits; mem_ready outside MEMRD/MEMWR SHALL be ignored.

Reset
REQ-034 rst_n low SHALL force state=FETCH, instret=0, illegal=0 immediately and mask pc_we, ir_we, regwrite, memread, memwrite and mem_req to 0 while low.
REQ-035 Reset asserted mid-access (MEMRD/MEMWR) SHALL abandon the access; first rising edge after release executes FETCH.

Structure
REQ-036 Package riscv_ctrl_pkg SHALL hold state encoding, opcode constants, aluctrl codes and alusrc/resultsrc/immsrc select codes.
REQ-037 Sub-module alu_decoder SHALL map {state class, funct3, funct7b5} to aluctrl combinationally; the FSM stays in multicycle_ctrl.

Verification
REQ-038 add (opcode 0110011, funct3 000, funct7b5 0) -> states FETCH,DECODE,EXECR,ALUWB,FETCH; aluctrl 0000 in EXECR; regwrite only in ALUWB; instret 0->1.
REQ-039 lw with mem_ready low 3 cycles -> MEMRD held 4 cycles with memread=mem_req=1, then MEMWB regwrite=1 resultsrc=01; total 8 cycles.
REQ-040 beq with zero=1 then zero=0 -> pc_we=1 then 0 in BEQ; both return to FETCH after 3 cycles.
REQ-041 opcode 1111111 -> ILLEGAL, illegal=1, all enables 0 for 20 cycles; rst_n pulse clears illegal and returns to FETCH.
REQ-042 rst_n low during MEMWR with mem_ready=0 -> memwrite/mem_req drop asynchronously, state=FETCH, instret=0.
REQ-043 srai (0010011, funct3 101, funct7b5 1) -> aluctrl 0111; addi with funct7b5=1 -> aluctrl 0000.
